// File: rtl/time_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : time_ctrl_pkg
// Description : Shared types, digit limits and helpers for the MM:SS
//               mode controller.
// Revision    : 1.0 - initial release
// ============================================================================
package time_ctrl_pkg;

    // Top-level operating modes
    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_SET  = 2'd2
    } state_t;

    // Editable field in SET, in the order the sel button walks them
    typedef enum logic [1:0] {
        F_MIN10 = 2'd0,
        F_MIN1  = 2'd1,
        F_SEC10 = 2'd2,
        F_SEC1  = 2'd3
    } field_t;

    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [3:0] ONES_MAX = 4'd9;

    // Increment a BCD digit, wrapping to 0 once it reaches its limit
    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

    // Blink-mask bit for a field: bit0 sec_1 ... bit3 min_10
    function automatic logic [3:0] field_onehot(input field_t f);
        logic [3:0] m;
        case (f)
            F_MIN10: m = 4'b1000;
            F_MIN1:  m = 4'b0100;
            F_SEC10: m = 4'b0010;
            F_SEC1:  m = 4'b0001;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge_sync
// Description : Two-flop synchronizer for an asynchronous button level plus
//               a delay flop; edge_out is high for one cycle per rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge_sync
    import time_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic edge_out
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Resynchronize the level and keep one extra stage for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign edge_out = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl
// Description : MM:SS mode controller. Counts time from the 1 Hz tick in RUN,
//               lets the user edit each digit in SET, drives the per-digit
//               blink mask and emits the hour carry.
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl
    import time_ctrl_pkg::*;
#(
    parameter int BLINK_DIV = 500
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_inc,
    output logic       run,
    output logic [3:0] sec_1,
    output logic [3:0] sec_10,
    output logic [3:0] min_1,
    output logic [3:0] min_10,
    output logic [3:0] blink_mask,
    output logic       carry_hour
);

    localparam int               C_CNT_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(BLINK_DIV - 1);

    // ------------------------------------------------------------------------
    // Button edge detection
    // ------------------------------------------------------------------------
    logic w_mode_raw;
    logic w_sel_raw;
    logic w_inc_raw;

    btn_edge_sync u_mode_sync (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_mode),
        .edge_out (w_mode_raw)
    );

    btn_edge_sync u_sel_sync (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_sel),
        .edge_out (w_sel_raw)
    );

    btn_edge_sync u_inc_sync (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_inc),
        .edge_out (w_inc_raw)
    );

    logic r_mode_edge;
    logic r_sel_edge;
    logic r_inc_edge;

    // Register the detected edges so the FSM sees clean one-cycle pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode_edge <= 1'b0;
            r_sel_edge  <= 1'b0;
            r_inc_edge  <= 1'b0;
        end else begin
            r_mode_edge <= w_mode_raw;
            r_sel_edge  <= w_sel_raw;
            r_inc_edge  <= w_inc_raw;
        end
    end

    // ------------------------------------------------------------------------
    // Mode FSM, digit registers and blink counter
    // ------------------------------------------------------------------------
    state_t             r_state;
    field_t             r_field;
    logic [3:0]         r_sec_1;
    logic [3:0]         r_sec_10;
    logic [3:0]         r_min_1;
    logic [3:0]         r_min_10;
    logic               r_run;
    logic               r_carry_hour;
    logic [C_CNT_W-1:0] r_blink_cnt;
    logic               r_phase;

    // Mode transitions, RUN counting with carry chain, SET digit editing and
    // the blink timebase that restarts whenever the edited digit changes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_STOP;
            r_field      <= F_MIN10;
            r_sec_1      <= 4'd0;
            r_sec_10     <= 4'd0;
            r_min_1      <= 4'd0;
            r_min_10     <= 4'd0;
            r_run        <= 1'b0;
            r_carry_hour <= 1'b0;
            r_blink_cnt  <= '0;
            r_phase      <= 1'b0;
        end else begin
            r_carry_hour <= 1'b0;
            case (r_state)
                ST_STOP: begin
                    r_blink_cnt <= '0;
                    r_phase     <= 1'b0;
                    if (r_mode_edge) begin
                        r_state <= ST_RUN;
                        r_run   <= 1'b1;
                    end else if (r_sel_edge) begin
                        r_state <= ST_SET;
                        r_field <= F_MIN10;
                    end
                end

                ST_RUN: begin
                    r_blink_cnt <= '0;
                    r_phase     <= 1'b0;
                    // A tick landing with the mode edge is still counted
                    if (tick_1hz) begin
                        r_sec_1 <= digit_inc(r_sec_1, ONES_MAX);
                        if (r_sec_1 == ONES_MAX) begin
                            r_sec_10 <= digit_inc(r_sec_10, TENS_MAX);
                            if (r_sec_10 == TENS_MAX) begin
                                r_min_1 <= digit_inc(r_min_1, ONES_MAX);
                                if (r_min_1 == ONES_MAX) begin
                                    r_min_10 <= digit_inc(r_min_10, TENS_MAX);
                                    if (r_min_10 == TENS_MAX) begin
                                        r_carry_hour <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    if (r_mode_edge) begin
                        r_state <= ST_STOP;
                        r_run   <= 1'b0;
                    end
                end

                ST_SET: begin
                    // inc always hits the field that is current this cycle,
                    // even when sel advances the field on the same edge
                    if (r_inc_edge) begin
                        case (r_field)
                            F_MIN10: r_min_10 <= digit_inc(r_min_10, TENS_MAX);
                            F_MIN1:  r_min_1  <= digit_inc(r_min_1,  ONES_MAX);
                            F_SEC10: r_sec_10 <= digit_inc(r_sec_10, TENS_MAX);
                            F_SEC1:  r_sec_1  <= digit_inc(r_sec_1,  ONES_MAX);
                            default: ;
                        endcase
                    end

                    if (r_mode_edge) begin
                        r_state     <= ST_STOP;
                        r_field     <= F_MIN10;
                        r_blink_cnt <= '0;
                        r_phase     <= 1'b0;
                    end else if (r_sel_edge) begin
                        if (r_field == F_SEC1) begin
                            r_state <= ST_STOP;
                            r_field <= F_MIN10;
                        end else begin
                            r_field <= field_t'(r_field + 2'd1);
                        end
                        r_blink_cnt <= '0;
                        r_phase     <= 1'b0;
                    end else if (r_inc_edge) begin
                        r_blink_cnt <= '0;
                        r_phase     <= 1'b0;
                    end else if (r_blink_cnt == C_CNT_MAX) begin
                        r_blink_cnt <= '0;
                        r_phase     <= ~r_phase;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_STOP;
                    r_field     <= F_MIN10;
                    r_run       <= 1'b0;
                    r_blink_cnt <= '0;
                    r_phase     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all derived directly from flops)
    // ------------------------------------------------------------------------
    assign run        = r_run;
    assign sec_1      = r_sec_1;
    assign sec_10     = r_sec_10;
    assign min_1      = r_min_1;
    assign min_10     = r_min_10;
    assign carry_hour = r_carry_hour;
    assign blink_mask = ((r_state == ST_SET) && r_phase) ? field_onehot(r_field) : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_ctrl
// Description : Self-checking bench for time_set_ctrl. A behavioural model
//               tracks mode, digits, edit field and blink age every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

    localparam int BLINK_DIV = 4;
    localparam int M_STOP = 0;
    localparam int M_RUN  = 1;
    localparam int M_SET  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_sel = 1'b0;
    logic       btn_inc = 1'b0;
    logic       run;
    logic [3:0] sec_1;
    logic [3:0] sec_10;
    logic [3:0] min_1;
    logic [3:0] min_10;
    logic [3:0] blink_mask;
    logic       carry_hour;

    time_set_ctrl #(.BLINK_DIV(BLINK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .btn_mode   (btn_mode),
        .btn_sel    (btn_sel),
        .btn_inc    (btn_inc),
        .run        (run),
        .sec_1      (sec_1),
        .sec_10     (sec_10),
        .min_1      (min_1),
        .min_10     (min_10),
        .blink_mask (blink_mask),
        .carry_hour (carry_hour)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model. Digits: m_dig[0]=sec_1 .. m_dig[3]=min_10.
    // Field 0..3 = MIN10, MIN1, SEC10, SEC1 -> digit index 3-field.
    // ------------------------------------------------------------------------
    int m_mode;
    int m_field;
    int m_dig[4];
    bit m_carry;
    int m_age;
    bit hm[5];
    bit hs[5];
    bit hi[5];

    task automatic model_reset();
        m_mode  = M_STOP;
        m_field = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_carry = 0;
        m_age   = 0;
        for (int i = 0; i < 5; i++) begin
            hm[i] = 0; hs[i] = 0; hi[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit ev_m, ev_s, ev_i, cleared;
        int secs, idx, lim;
        for (int i = 4; i > 0; i--) begin
            hm[i] = hm[i-1]; hs[i] = hs[i-1]; hi[i] = hi[i-1];
        end
        hm[0] = btn_mode; hs[0] = btn_sel; hi[0] = btn_inc;
        // A rising level sampled at edge k acts on edge k+3
        ev_m = hm[3] && !hm[4];
        ev_s = hs[3] && !hs[4];
        ev_i = hi[3] && !hi[4];
        m_carry = 0;
        cleared = 0;
        case (m_mode)
            M_STOP: begin
                if (ev_m) m_mode = M_RUN;
                else if (ev_s) begin
                    m_mode = M_SET; m_field = 0; cleared = 1;
                end
            end
            M_RUN: begin
                if (tick_1hz) begin
                    secs = m_dig[3]*600 + m_dig[2]*60 + m_dig[1]*10 + m_dig[0];
                    m_carry = (secs == 3599);
                    secs = (secs + 1) % 3600;
                    m_dig[3] = secs / 600;
                    m_dig[2] = (secs / 60) % 10;
                    m_dig[1] = (secs % 60) / 10;
                    m_dig[0] = secs % 10;
                end
                if (ev_m) m_mode = M_STOP;
            end
            default: begin
                if (ev_i) begin
                    idx = 3 - m_field;
                    lim = (idx % 2 == 1) ? 5 : 9;
                    m_dig[idx] = (m_dig[idx] + 1) % (lim + 1);
                    cleared = 1;
                end
                if (ev_m) m_mode = M_STOP;
                else if (ev_s) begin
                    if (m_field == 3) m_mode = M_STOP;
                    else begin
                        m_field++; cleared = 1;
                    end
                end
                if (!cleared) m_age++;
            end
        endcase
        if (cleared || m_mode != M_SET) m_age = 0;
    endtask

    task automatic check_all();
        logic [15:0] exp_disp;
        logic [3:0]  exp_mask;
        exp_disp = {m_dig[3][3:0], m_dig[2][3:0], m_dig[1][3:0], m_dig[0][3:0]};
        exp_mask = 4'b0000;
        if (m_mode == M_SET && ((m_age / BLINK_DIV) % 2) == 1)
            exp_mask = 4'(1 << (3 - m_field));
        check("run",        {31'd0, run}, (m_mode == M_RUN) ? 32'd1 : 32'd0);
        check("digits",     {16'd0, min_10, min_1, sec_10, sec_1}, {16'd0, exp_disp});
        check("blink_mask", {28'd0, blink_mask}, {28'd0, exp_mask});
        check("carry_hour", {31'd0, carry_hour}, {31'd0, m_carry});
    endtask

    function automatic logic [31:0] disp();
        return {16'd0, min_10, min_1, sec_10, sec_1};
    endfunction

    // One clock: model follows the edge, outputs compared 1 time unit later
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        #1;
        check_all();
    endtask

    task automatic settle(input int n);
        repeat (n) cycle();
    endtask

    // which: 0 mode, 1 sel, 2 inc
    task automatic press(input int which);
        if (which == 0) btn_mode = 1'b1;
        else if (which == 1) btn_sel = 1'b1;
        else btn_inc = 1'b1;
        cycle();
        btn_mode = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0;
        cycle();
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        cycle();
        tick_1hz = 1'b0;
        cycle();
    endtask

    int exp7[7] = '{1, 2, 3, 4, 5, 0, 1};

    initial begin
        model_reset();
        rst = 1'b0;
        settle(3);
        check("rst_digits", disp(), 32'h0000);
        rst = 1'b1;
        settle(2);

        // RUN for one minute
        press(0); settle(4);
        repeat (60) do_tick();
        check("t1_disp", disp(), 32'h0100);
        check("t1_run",  {31'd0, run}, 32'd1);

        // Preload 59:58 through SET
        press(0); settle(4);
        press(1); settle(2);
        repeat (5) press(2);
        press(1); settle(2);
        repeat (8) press(2);
        press(1); settle(2);
        repeat (5) press(2);
        press(1); settle(2);
        repeat (8) press(2);
        press(1); settle(5);
        check("t2_preload", disp(), 32'h5958);

        // Roll over the hour
        press(0); settle(4);
        do_tick();
        check("t2_5959", disp(), 32'h5959);
        tick_1hz = 1'b1;
        cycle();
        tick_1hz = 1'b0;
        check("t2_roll",  disp(), 32'h0000);
        check("t2_carry", {31'd0, carry_hour}, 32'd1);
        cycle();
        check("t2_carry_end", {31'd0, carry_hour}, 32'd0);

        // Digit editing without carry
        press(0); settle(4);
        press(1); settle(3);
        for (int i = 0; i < 7; i++) begin
            press(2); settle(2);
            check("t3_min10", {28'd0, min_10}, exp7[i]);
        end
        press(1); settle(3);
        repeat (12) press(2);
        settle(3);
        check("t3_disp", disp(), 32'h1200);

        // Blink on SEC10, inc restart, ticks ignored in SET
        press(1); settle(20);
        press(2); settle(10);
        repeat (3) do_tick();
        check("t4_disp", disp(), 32'h1210);

        // sel and inc together: inc lands on SEC10, field moves to SEC1
        btn_sel = 1'b1; btn_inc = 1'b1;
        cycle();
        btn_sel = 1'b0; btn_inc = 1'b0;
        settle(4);
        check("t5_disp", disp(), 32'h1220);
        press(1); settle(4);
        check("t5_stop_run",  {31'd0, run}, 32'd0);
        check("t5_stop_mask", {28'd0, blink_mask}, 32'd0);

        // Tick and mode edge together in RUN
        press(0); settle(4);
        do_tick(); do_tick();
        btn_mode = 1'b1; cycle();
        btn_mode = 1'b0; cycle();
        cycle();
        tick_1hz = 1'b1; cycle();
        tick_1hz = 1'b0;
        check("t6_run",  {31'd0, run}, 32'd0);
        check("t6_disp", disp(), 32'h1223);
        settle(3);

        // Reach 12:34 in SET, then reset with inc held
        press(1); settle(2);
        press(1); settle(2);
        press(1); settle(2);
        press(2); settle(2);
        press(1); settle(2);
        press(2); settle(3);
        check("t7_pre", disp(), 32'h1234);
        btn_inc = 1'b1;
        cycle();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        check("t7_rst_disp", disp(), 32'h0000);
        settle(3);
        rst = 1'b1;
        settle(8);
        check("t7_after_disp", disp(), 32'h0000);
        check("t7_after_run",  {31'd0, run}, 32'd0);
        btn_inc = 1'b0;
        settle(3);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 9) == 0)  btn_sel  = ~btn_sel;
            if ($urandom_range(0, 5) == 0)  btn_inc  = ~btn_inc;
            tick_1hz = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rst = 1'b1; tick_1hz = 1'b0;
        btn_mode = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0;
        settle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
